// File: rtl/tcam_pkg.sv
// Shared mode encoding for the routing TCAM.
package tcam_pkg;

    localparam logic [2:0] MODE_I   = 3'b000;
    localparam logic [2:0] MODE_W   = 3'b001;
    localparam logic [2:0] MODE_R   = 3'b010;
    localparam logic [2:0] MODE_F   = 3'b011;
    localparam logic [2:0] MODE_C   = 3'b100;
    localparam logic [2:0] MODE_RST = 3'b101;

    typedef enum logic [2:0] {
        ModeIdle    = MODE_I,
        ModeWrite   = MODE_W,
        ModeRead    = MODE_R,
        ModeFire    = MODE_F,
        ModeCompare = MODE_C,
        ModeReset   = MODE_RST,
        ModeRsvd6   = 3'b110,
        ModeRsvd7   = 3'b111
    } mode_e;

endpackage

// File: rtl/tcam_prio_enc.sv
// Lowest-index priority encoder over the TCAM hit vector.
module tcam_prio_enc #(
    parameter int unsigned Words = 16,
    parameter int unsigned IdxW  = 4
) (
    input  logic [Words-1:0] i_hit,
    output logic [IdxW-1:0]  o_idx,
    output logic             o_any
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        o_idx = '0;
        o_any = |i_hit;
        for (int i = int'(Words) - 1; i >= 0; i--) begin
            if (i_hit[i]) begin
                o_idx = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/tcam_mem.sv
// Neuromorphic routing TCAM: ternary lookup of spike packet IDs to destination IDs.
module tcam_mem
    import tcam_pkg::*;
#(
    parameter int unsigned ID_Width    = 4,
    parameter int unsigned AddressSize = 4,
    parameter int unsigned Bits        = 8,
    parameter int unsigned Words       = 2 ** AddressSize,
    parameter int unsigned BankSize    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             MODE,
    input  logic [ID_Width-1:0]    PacketID_In,
    input  logic [Bits-1:0]        Data_In,
    input  logic [Bits-1:0]        Mskb_In,
    input  logic [AddressSize-1:0] A_In,
    input  logic                   Dcs_In,
    input  logic                   Vbe_In,
    input  logic                   Vbi_In,
    output logic [Bits-1:0]        Data_Out,
    output logic                   Vbo_Out,
    output logic [Words-1:0]       HitLine_Out,
    output logic [BankSize-1:0]    Hit_Out,
    output logic [ID_Width-1:0]    DstID_Out,
    output logic                   Fire_Vld_Out
);

    localparam int unsigned WordsPerBank = Words / BankSize;

    mode_e w_mode;
    assign w_mode = mode_e'(MODE);

    // Entry storage
    logic [Bits-1:0]  r_data [Words];
    logic [Bits-1:0]  r_care [Words];
    logic [Words-1:0] r_valid;

    // Registered outputs
    logic [Bits-1:0]     r_data_out;
    logic                r_vbo;
    logic [Words-1:0]    r_hitline;
    logic [BankSize-1:0] r_hit;
    logic [ID_Width-1:0] r_dst;
    logic                r_fire_vld;

    // Search key/mask and lookup results
    logic [Bits-1:0]        w_key;
    logic [Bits-1:0]        w_mask;
    logic [Words-1:0]       w_hitline;
    logic [BankSize-1:0]    w_bank_hit;
    logic [AddressSize-1:0] w_hit_idx;
    logic                   w_any_hit;
    logic [ID_Width-1:0]    w_fire_dst;

    // Fire searches only the key field with the packet ID; compare uses the raw bus
    always_comb begin
        w_key  = Data_In;
        w_mask = Mskb_In;
        if (w_mode == ModeFire) begin
            w_key                       = '0;
            w_key[Bits-1 -: ID_Width]   = PacketID_In;
            w_mask                      = '0;
            w_mask[Bits-1 -: ID_Width]  = '1;
        end
    end

    // A bit mismatches only if both the search mask and the entry care bit select it
    for (genvar e = 0; e < Words; e++) begin : g_match
        assign w_hitline[e] = r_valid[e] &&
                              (((r_data[e] ^ w_key) & w_mask & r_care[e]) == '0);
    end

    // Per-bank OR of the hit vector
    always_comb begin
        w_bank_hit = '0;
        for (int b = 0; b < int'(BankSize); b++) begin
            w_bank_hit[b] = |w_hitline[b*WordsPerBank +: WordsPerBank];
        end
    end

    tcam_prio_enc #(
        .Words (Words),
        .IdxW  (AddressSize)
    ) u_prio_enc (
        .i_hit (w_hitline),
        .o_idx (w_hit_idx),
        .o_any (w_any_hit)
    );

    assign w_fire_dst = r_data[w_hit_idx][ID_Width-1:0];

    // Entry array: cleared by either reset, updated by writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < int'(Words); e++) begin
                r_data[e] <= '0;
                r_care[e] <= '1;
            end
            r_valid <= '0;
        end else if (w_mode == ModeReset) begin
            for (int e = 0; e < int'(Words); e++) begin
                r_data[e] <= '0;
                r_care[e] <= '1;
            end
            r_valid <= '0;
        end else if (w_mode == ModeWrite) begin
            if (Dcs_In) begin
                r_data[A_In] <= Data_In;
            end else begin
                r_care[A_In] <= Mskb_In;
            end
            if (Vbe_In) begin
                r_valid[A_In] <= Vbi_In;
            end
        end
    end

    // Output registers: each result holds until its own operation refreshes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
            r_vbo      <= 1'b0;
            r_hitline  <= '0;
            r_hit      <= '0;
            r_dst      <= '0;
            r_fire_vld <= 1'b0;
        end else begin
            r_fire_vld <= 1'b0;
            case (w_mode)
                ModeRead: begin
                    r_data_out <= Dcs_In ? r_data[A_In] : r_care[A_In];
                    r_vbo      <= Vbe_In ? r_valid[A_In] : 1'b0;
                end
                ModeCompare: begin
                    r_hitline <= w_hitline;
                    r_hit     <= w_bank_hit;
                end
                ModeFire: begin
                    r_hitline  <= w_hitline;
                    r_hit      <= w_bank_hit;
                    r_dst      <= w_any_hit ? w_fire_dst : '0;
                    r_fire_vld <= w_any_hit;
                end
                ModeReset: begin
                    r_data_out <= '0;
                    r_vbo      <= 1'b0;
                    r_hitline  <= '0;
                    r_hit      <= '0;
                    r_dst      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign Data_Out     = r_data_out;
    assign Vbo_Out      = r_vbo;
    assign HitLine_Out  = r_hitline;
    assign Hit_Out      = r_hit;
    assign DstID_Out    = r_dst;
    assign Fire_Vld_Out = r_fire_vld;

endmodule

// File: tb/tb_tcam_mem.sv
// Self-checking bench for tcam_mem: directed scenarios plus randomized operations
// against a per-entry reference model.
module tb_tcam_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  MODE = 3'd0;
    logic [3:0]  PacketID_In = '0;
    logic [7:0]  Data_In = '0;
    logic [7:0]  Mskb_In = '0;
    logic [3:0]  A_In = '0;
    logic        Dcs_In = 1'b0;
    logic        Vbe_In = 1'b0;
    logic        Vbi_In = 1'b0;
    logic [7:0]  Data_Out;
    logic        Vbo_Out;
    logic [15:0] HitLine_Out;
    logic [0:0]  Hit_Out;
    logic [3:0]  DstID_Out;
    logic        Fire_Vld_Out;

    tcam_mem dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MODE         (MODE),
        .PacketID_In  (PacketID_In),
        .Data_In      (Data_In),
        .Mskb_In      (Mskb_In),
        .A_In         (A_In),
        .Dcs_In       (Dcs_In),
        .Vbe_In       (Vbe_In),
        .Vbi_In       (Vbi_In),
        .Data_Out     (Data_Out),
        .Vbo_Out      (Vbo_Out),
        .HitLine_Out  (HitLine_Out),
        .Hit_Out      (Hit_Out),
        .DstID_Out    (DstID_Out),
        .Fire_Vld_Out (Fire_Vld_Out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0]  m_data [16];
    logic [7:0]  m_care [16];
    logic        m_valid [16];
    logic [7:0]  e_dout;
    logic        e_vbo;
    logic [15:0] e_hl;
    logic        e_hit;
    logic [3:0]  e_dst;
    logic        e_fire;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int e = 0; e < 16; e++) begin
            m_data[e]  = 8'h00;
            m_care[e]  = 8'hFF;
            m_valid[e] = 1'b0;
        end
        e_dout = '0; e_vbo = 0; e_hl = '0; e_hit = 0; e_dst = '0; e_fire = 0;
    endtask

    function automatic logic m_match(int e, logic [7:0] k, logic [7:0] m);
        if (!m_valid[e]) return 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m[i] && m_care[e][i] && (m_data[e][i] != k[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".dout"},  {24'd0, Data_Out},    {24'd0, e_dout});
        chk({tag, ".vbo"},   {31'd0, Vbo_Out},     {31'd0, e_vbo});
        chk({tag, ".hl"},    {16'd0, HitLine_Out}, {16'd0, e_hl});
        chk({tag, ".hit"},   {31'd0, Hit_Out},     {31'd0, e_hit});
        chk({tag, ".dst"},   {28'd0, DstID_Out},   {28'd0, e_dst});
        chk({tag, ".fire"},  {31'd0, Fire_Vld_Out}, {31'd0, e_fire});
    endtask

    // Apply one operation for one cycle, advance the model, check every output
    task automatic do_op(input logic [2:0] mode, input logic [3:0] pid, input logic [7:0] din,
                         input logic [7:0] msk, input logic [3:0] a, input logic dcs,
                         input logic vbe, input logic vbi, input string tag);
        logic [7:0] k, m;
        bit found;
        @(negedge clk);
        MODE = mode; PacketID_In = pid; Data_In = din; Mskb_In = msk;
        A_In = a; Dcs_In = dcs; Vbe_In = vbe; Vbi_In = vbi;
        e_fire = 1'b0;
        case (mode)
            3'd1: begin
                if (dcs) m_data[a] = din;
                else     m_care[a] = msk;
                if (vbe) m_valid[a] = vbi;
            end
            3'd2: begin
                e_dout = dcs ? m_data[a] : m_care[a];
                e_vbo  = vbe ? m_valid[a] : 1'b0;
            end
            3'd3, 3'd4: begin
                if (mode == 3'd3) begin
                    k = {pid, 4'h0}; m = 8'hF0;
                end else begin
                    k = din; m = msk;
                end
                for (int e = 0; e < 16; e++) e_hl[e] = m_match(e, k, m);
                e_hit = (e_hl != 16'd0);
                if (mode == 3'd3) begin
                    e_dst = 4'h0;
                    found = 0;
                    for (int e = 0; e < 16; e++) begin
                        if (!found && e_hl[e]) begin
                            found  = 1;
                            e_dst  = m_data[e][3:0];
                            e_fire = 1'b1;
                        end
                    end
                end
            end
            3'd5: model_reset();
            default: ;
        endcase
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [2:0] md;
        logic [3:0] ra, rp;
        logic [7:0] rd, rm;

        model_reset();
        // Async reset
        #12;
        chk("rst.dout", {24'd0, Data_Out}, 32'd0);
        chk("rst.fire", {31'd0, Fire_Vld_Out}, 32'd0);
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: mode reset, care array reads all-ones, valid clear
        do_op(3'd5, 4'h0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, "t1_mrst");
        do_op(3'd2, 4'h0, 8'h00, 8'h00, 4'd1, 1'b0, 1'b1, 1'b0, "t1_rd");
        chk("t1.dout_ff", {24'd0, Data_Out}, 32'hFF);
        chk("t1.vbo0", {31'd0, Vbo_Out}, 32'd0);

        // 2: write data 0 with valid, read back
        do_op(3'd1, 4'h0, 8'h00, 8'h00, 4'd1, 1'b1, 1'b1, 1'b1, "t2_wr");
        do_op(3'd2, 4'h0, 8'h00, 8'h00, 4'd1, 1'b1, 1'b1, 1'b0, "t2_rd");
        chk("t2.vbo1", {31'd0, Vbo_Out}, 32'd1);

        // 3: two identical entries, exact compare
        do_op(3'd1, 4'h0, 8'h5A, 8'h00, 4'd3, 1'b1, 1'b1, 1'b1, "t3_wr3");
        do_op(3'd1, 4'h0, 8'h5A, 8'h00, 4'd7, 1'b1, 1'b1, 1'b1, "t3_wr7");
        do_op(3'd4, 4'h0, 8'h5A, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, "t3_cmp");
        chk("t3.hl_0088", {16'd0, HitLine_Out}, 32'h0088);
        chk("t3.hit1", {31'd0, Hit_Out}, 32'd1);

        // 4: fire hits lowest entry; pulse is one cycle wide
        do_op(3'd3, 4'h5, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, "t4_fire");
        chk("t4.dst_a", {28'd0, DstID_Out}, 32'hA);
        chk("t4.fire1", {31'd0, Fire_Vld_Out}, 32'd1);
        do_op(3'd0, 4'h0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, "t4_idle");
        chk("t4.fire_drop", {31'd0, Fire_Vld_Out}, 32'd0);

        // 5: fire miss
        do_op(3'd3, 4'h6, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, "t5_fire");
        chk("t5.hl0", {16'd0, HitLine_Out}, 32'd0);
        chk("t5.dst0", {28'd0, DstID_Out}, 32'd0);

        // 6: invalidate entry 3, narrow care of entry 7
        do_op(3'd1, 4'h0, 8'h5A, 8'h00, 4'd3, 1'b1, 1'b1, 1'b0, "t6_inv3");
        do_op(3'd1, 4'h0, 8'h00, 8'h0F, 4'd7, 1'b0, 1'b0, 1'b0, "t6_care7");
        do_op(3'd4, 4'h0, 8'h3A, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, "t6_cmp");
        chk("t6.hl_0080", {16'd0, HitLine_Out}, 32'h0080);

        // Illegal modes behave as idle
        do_op(3'd6, 4'h5, 8'hFF, 8'hFF, 4'd7, 1'b1, 1'b1, 1'b0, "ill6");
        do_op(3'd7, 4'h5, 8'hFF, 8'hFF, 4'd7, 1'b0, 1'b1, 1'b0, "ill7");

        // Randomized operations, weighted toward writes so lookups find entries
        for (int n = 0; n < 400; n++) begin
            md = 3'($urandom_range(0, 9));
            if (md > 3'd7 || ($urandom_range(0, 3) == 0)) md = 3'd1;
            if (md == 3'd5 && $urandom_range(0, 3) != 0) md = 3'd4;
            ra = 4'($urandom_range(0, 15));
            rd = 8'($urandom);
            rm = 8'($urandom);
            rp = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rp = m_data[ra][7:4];
                if (md == 3'd4) rd = m_data[ra] ^ (8'($urandom) & ~rm);
            end
            do_op(md, rp, rd, rm, ra, 1'($urandom), 1'($urandom), 1'($urandom), "rnd");
            if (n == 200) begin
                // Asynchronous reset mid-cycle clears everything immediately
                #3;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
